// File: rtl/z80_bus_pkg.sv
// ============================================================================
// Module   : z80_bus_pkg
// Brief    : Shared types and constants for the Z80-style memory bus master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package z80_bus_pkg;

  localparam int Z80_ADDR_W = 16;
  localparam int Z80_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TA   = 3'd4,
    TW   = 3'd5
  } bus_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_t;

endpackage

`default_nettype wire

// File: rtl/z80_bus_master.sv
// ============================================================================
// Module   : z80_bus_master
// Brief    : Single-beat request -> fixed T1/T2/T3 Z80-style bus cycle master.
//            Optional wait states via macro Z80_BUS_WAIT_EN (adds WAIT_L, TW).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_bus_master
  import z80_bus_pkg::*;
#(
  parameter int TURNAROUND = 1,
  parameter int ADDR_W     = Z80_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [Z80_DATA_W-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [Z80_DATA_W-1:0] resp_rdata,
`ifdef Z80_BUS_WAIT_EN
  input  logic                  WAIT_L,
`endif
  output logic                  MREQ_L,
  output logic                  RD_L,
  output logic                  WR_L,
  inout  wire  [ADDR_W-1:0]     addr_bus,
  inout  wire  [Z80_DATA_W-1:0] data_bus
);

  localparam logic [1:0] c_ta_load = 2'(TURNAROUND);

  bus_state_t            r_state;
  bus_state_t            w_next;
  bus_op_t               r_op;
  logic [1:0]            r_ta_cnt;
  logic [1:0]            w_ta_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [Z80_DATA_W-1:0] r_wdata;
  logic [Z80_DATA_W-1:0] r_rdata;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_addr_phase;
  logic                  w_strobe_phase;
  logic                  w_is_read;

  assign req_ready = ~rst & (r_state == IDLE) & (r_ta_cnt == 2'd0);
  assign w_accept  = req_valid & req_ready;
  assign w_is_read = (r_op == OP_READ);

  always_comb begin
    w_next    = r_state;
    w_ta_next = r_ta_cnt;
    w_capture = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = T1;
      T1:   w_next = T2;
`ifdef Z80_BUS_WAIT_EN
      T2: begin
        if (!WAIT_L) begin
          w_next = TW;
        end else begin
          w_next    = T3;
          w_capture = w_is_read;
        end
      end
      TW: begin
        if (WAIT_L) begin
          w_next    = T3;
          w_capture = w_is_read;
        end
      end
`else
      T2: begin
        w_next    = T3;
        w_capture = w_is_read;
      end
`endif
      T3: begin
        if (w_is_read && (TURNAROUND > 0)) begin
          w_next    = TA;
          w_ta_next = c_ta_load;
        end else begin
          w_next = IDLE;
        end
      end
      TA: begin
        w_ta_next = r_ta_cnt - 2'd1;
        if (r_ta_cnt <= 2'd1) begin
          w_next    = IDLE;
          w_ta_next = 2'd0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ta_cnt <= 2'd0;
      r_op     <= OP_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_ta_cnt <= w_ta_next;
      if (w_accept) begin
        r_op    <= bus_op_t'(req_we);
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_capture) r_rdata <= data_bus;
    end
  end

  // Bus pins decode from the state register only, so they move on posedge or reset.
  assign w_addr_phase   = (r_state == T1) | (r_state == T2) | (r_state == T3) | (r_state == TW);
  assign w_strobe_phase = (r_state == T1) | (r_state == T2) | (r_state == TW);

  assign MREQ_L     = ~w_strobe_phase;
  assign RD_L       = ~(w_strobe_phase & w_is_read);
  assign WR_L       = ~(((r_state == T2) | (r_state == TW)) & ~w_is_read);
  assign resp_valid = (r_state == T3);
  assign resp_rdata = r_rdata;

  assign addr_bus = w_addr_phase ? r_addr : {ADDR_W{1'bz}};
  assign data_bus = (w_addr_phase & ~w_is_read) ? r_wdata : {Z80_DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: doc/z80_bus_master.md
Name: z80_bus_master

Overview:
- CPU-side initiator for the Z80-style memory bus (MREQ_L, RD_L, WR_L, 8-bit data_bus, 16-bit addr_bus).
- Converts single-beat internal read/write requests into fixed T1/T2/T3 bus cycles, matched to the memory responder:
  - The responder drives read data on the clock after it samples RD_L low.
  - The responder captures write data while WR_L is low.
- Sits between the core's fetch/load-store logic and the shared bus. It is the only bus driver of addresses and strobes.

Parameters:
- TURNAROUND, 1, idle cycles inserted after a read before the next accepted request (0..3). Guarantees the responder has released data_bus.
- ADDR_W, 16, address width. Fixed by the bus; exposed only for package consistency.

Ports:
- clk  input  1  bus clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block accepts the request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  16  target address.
- req_wdata  input  8  write data.
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  8  read data; valid with resp_valid on reads, holds value otherwise.
- MREQ_L  output  1  memory request strobe, active low.
- RD_L  output  1  read strobe, active low.
- WR_L  output  1  write strobe, active low.
- addr_bus  inout  16  driven during T1..T3, Z otherwise.
- data_bus  inout  8  driven by this block during write T1..T3 only, Z otherwise.

Behaviour:
- Reset, asynchronous, checked first:
  - State is IDLE and the turnaround counter is 0.
  - MREQ_L, RD_L and WR_L are 1.
  - addr_bus and data_bus are Z.
  - req_ready is 0 while rst is high, and 1 in the first cycle after release.
  - resp_valid is 0 and resp_rdata is 8'h00.
- Reset mid-cycle aborts the access:
  - No resp_valid is issued.
  - Strobes deassert and buses go Z immediately, without waiting for a clock.
- All bus outputs are registered (decoded from the state register), so they change only on posedge or on reset.
- States: IDLE, T1, T2, T3, TA (turnaround).
- IDLE:
  - req_ready = (turnaround counter == 0).
  - On req_valid & req_ready: latch addr/we/wdata, go to T1.
- T1:
  - addr_bus is driven and MREQ_L = 0.
  - Read: RD_L = 0.
  - Write: data_bus is driven with the latched wdata and WR_L stays 1.
  - Always goes to T2.
- T2:
  - Read: MREQ_L and RD_L stay 0. The responder's data is on the bus. At the posedge ending T2, data_bus is captured into resp_rdata.
  - Write: WR_L = 0 and data is held.
  - Goes to T3.
- T3:
  - MREQ_L, RD_L and WR_L are 1. addr_bus is still driven.
  - Write data is held through T3 as hold time for the responder's register.
  - resp_valid = 1.
  - Read goes to TA when TURNAROUND > 0, otherwise to IDLE. Write goes to IDLE.
- TA: counts TURNAROUND cycles with all outputs idle, then goes to IDLE.
- Minimum cost: 4 cycles per write, 4+TURNAROUND cycles per read. No pipelining, one outstanding access.
- req_ready is 0 in every state except IDLE. A request held across busy cycles is accepted in the first IDLE cycle.
- Req inputs are sampled only at acceptance; later changes are ignored.
- Address 16'hFFFF and 16'h0000 need no special handling; there is no wrap logic.
- data_bus is never driven in the same cycle a read strobe is low.

Optional Feature:
- Macro Z80_BUS_WAIT_EN.
- When defined:
  - Adds input WAIT_L (1 bit, active low) and state TW.
  - WAIT_L is sampled at the posedge ending T2. If it is 0, the block goes to TW instead of T3.
  - TW holds all T2 outputs and loops while WAIT_L = 0, then goes to T3.
  - Read data is captured at the posedge ending the last T2/TW cycle.
- When undefined: no WAIT_L port, no TW state, and timing is exactly as above.

Decomposition:
- Shared package z80_bus_pkg holds:
  - bus_state_t enum (IDLE, T1, T2, T3, TA, TW).
  - bus_op_t (OP_READ, OP_WRITE).
  - Constants Z80_ADDR_W = 16, Z80_DATA_W = 8.
- No sub-module: the FSM, turnaround counter and tristate drivers are flat in one module.

Test Plan:
- Reset then read: bench memory holds 8'hA5 at 16'h0010. Read at 16'h0010 -> MREQ_L/RD_L low for exactly 2 cycles, resp_valid 1 in T3 with resp_rdata = 8'hA5.
- Write then read back: write 8'h3C to 16'h0020 -> WR_L low for 1 cycle, data_bus = 8'h3C for T1..T3. A subsequent read of 16'h0020 returns 8'h3C.
- Back-to-back with req_valid held high: read, then write, TURNAROUND = 1 -> the write's T1 starts exactly 2 cycles after the read's T3. data_bus is never driven by both sides (no X on the bus).
- Async reset asserted during T2 of a write -> strobes go to 1 and buses go to Z before the next posedge, no resp_valid, and req_ready = 1 the cycle after rst falls.
- Edge addresses: reads of 16'h0000 and 16'hFFFF -> correct data and resp_valid timing identical to the mid-range case.
- With Z80_BUS_WAIT_EN: WAIT_L low for 3 cycles during a read -> 3 TW cycles, RD_L low for 5 cycles total, resp_rdata equals the bus value at the last TW edge.
